// File: rtl/vend_ctrl_param.sv
// Coin-credit vending controller: edge-detected coins, binary credit counter,
// vend pulse, and spaced change/refund payout with optional keep-remainder mode.
module vend_ctrl_param #(
  parameter int CW          = 3,
  parameter int CREDIT_MAX  = 4,
  parameter int PRICE       = 3,
  parameter int VAL_A       = 1,
  parameter int VAL_B       = 2,
  parameter int AUTO_CHANGE = 1,
  parameter int CHG_GAP     = 2
) (
  input  logic                  Hz,
  input  logic                  Reset,
  input  logic                  coin_a,
  input  logic                  coin_b,
  input  logic                  buy,
  input  logic                  refund,
  output logic [CW-1:0]         credit,
  output logic [CREDIT_MAX-1:0] money,
  output logic                  enough,
  output logic                  vend,
  output logic                  change,
  output logic                  reject,
  output logic                  busy
);

  localparam int GW = $clog2(CHG_GAP + 1);
  localparam logic [CW+1:0] VA_W    = (CW+2)'(VAL_A);
  localparam logic [CW+1:0] VB_W    = (CW+2)'(VAL_B);
  localparam logic [CW+1:0] CMAX_W  = (CW+2)'(CREDIT_MAX);
  localparam logic [CW-1:0] PRICE_C = CW'(PRICE);
  localparam logic [GW-1:0] GAP_C   = GW'(CHG_GAP);

  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] credit_n;
  logic [GW-1:0] gap, gap_n;
  logic          vend_n, change_n, reject_n;
  logic          coin_a_q, coin_b_q, buy_q, refund_q;
  logic          ea, eb, ebuy, eref;
  logic [CW+1:0] dep;

  // Sum is formed two bits wider than the counter so it can never wrap.
  function automatic logic fits(input logic [CW-1:0] c, input logic [CW+1:0] add);
    return (({2'b00, c} + add) <= CMAX_W);
  endfunction

  assign ea   = coin_a & ~coin_a_q;
  assign eb   = coin_b & ~coin_b_q;
  assign ebuy = ~buy & buy_q;
  assign eref = refund & ~refund_q;
  assign dep  = (ea ? VA_W : '0) + (eb ? VB_W : '0);

  always_comb begin
    state_n  = state;
    credit_n = credit;
    gap_n    = gap;
    vend_n   = 1'b0;
    change_n = 1'b0;
    reject_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (ea || eb) begin
          if (fits(credit, dep)) credit_n = credit + dep[CW-1:0];
          else                   reject_n = 1'b1;
        end else if (ebuy && credit >= PRICE_C) begin
          credit_n = credit - PRICE_C;
          vend_n   = 1'b1;
          state_n  = VEND;
        end else if (eref && credit != '0) begin
          change_n = 1'b1;
          gap_n    = '0;
          state_n  = CHANGE;
        end
      end
      VEND: begin
        reject_n = ea | eb;
        if (AUTO_CHANGE != 0 && credit != '0) begin
          change_n = 1'b1;
          gap_n    = '0;
          state_n  = CHANGE;
        end else begin
          state_n = IDLE;
        end
      end
      CHANGE: begin
        reject_n = ea | eb;
        // A unit is retired at the end of its pulse cycle; the last one skips the gap.
        if (change) begin
          credit_n = credit - 1'b1;
          if (credit == CW'(1)) state_n = IDLE;
          else                  gap_n   = GAP_C;
        end else if (gap > GW'(1)) begin
          gap_n = gap - 1'b1;
        end else begin
          gap_n    = '0;
          change_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Hz or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      credit   <= '0;
      gap      <= '0;
      vend     <= 1'b0;
      change   <= 1'b0;
      reject   <= 1'b0;
      coin_a_q <= 1'b0;
      coin_b_q <= 1'b0;
      buy_q    <= 1'b1;
      refund_q <= 1'b0;
    end else begin
      state    <= state_n;
      credit   <= credit_n;
      gap      <= gap_n;
      vend     <= vend_n;
      change   <= change_n;
      reject   <= reject_n;
      coin_a_q <= coin_a;
      coin_b_q <= coin_b;
      buy_q    <= buy;
      refund_q <= refund;
    end
  end

  assign busy   = (state != IDLE);
  assign enough = (state == IDLE) && (credit >= PRICE_C);

  always_comb begin
    money = '0;
    for (int i = 0; i < CREDIT_MAX; i++) money[i] = ({2'b00, credit} > (CW+2)'(i));
  end

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Bench for vend_ctrl_param: table of per-cycle vectors through a scoreboard
// queue, plus hand-written keep-remainder and reset-during-payout sequences.
module tb_vend_ctrl_param;

  logic       Hz = 1'b0;
  logic       Reset;
  logic       coin_a, coin_b, buy, refund;
  logic [2:0] credit, k_credit;
  logic [3:0] money, k_money;
  logic       enough, vend, change, reject, busy;
  logic       k_enough, k_vend, k_change, k_reject, k_busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       a, b, bn, r;
    logic [2:0] credit;
    logic       vend, change, reject, busy, enough;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  always #5 Hz = ~Hz;

  vend_ctrl_param u_dut (
    .Hz(Hz), .Reset(Reset), .coin_a(coin_a), .coin_b(coin_b), .buy(buy), .refund(refund),
    .credit(credit), .money(money), .enough(enough), .vend(vend), .change(change),
    .reject(reject), .busy(busy)
  );

  vend_ctrl_param #(.AUTO_CHANGE(0)) u_keep (
    .Hz(Hz), .Reset(Reset), .coin_a(coin_a), .coin_b(coin_b), .buy(buy), .refund(refund),
    .credit(k_credit), .money(k_money), .enough(k_enough), .vend(k_vend), .change(k_change),
    .reject(k_reject), .busy(k_busy)
  );

  function automatic logic [3:0] therm(input logic [2:0] c);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = (int'(c) > i);
    return m;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic a, input logic b, input logic bn, input logic r,
                     input logic [2:0] c, input logic v, input logic ch, input logic rj,
                     input logic bz, input logic en);
    vec_t t;
    t.a = a; t.b = b; t.bn = bn; t.r = r;
    t.credit = c; t.vend = v; t.change = ch; t.reject = rj; t.busy = bz; t.enough = en;
    tbl.push_back(t);
  endtask

  task automatic tick();
    @(posedge Hz);
    #1;
  endtask

  task automatic drive(input logic a, input logic b, input logic bn, input logic r);
    coin_a = a; coin_b = b; buy = bn; refund = r;
  endtask

  task automatic step(input int idx, input vec_t t);
    vec_t e;
    drive(t.a, t.b, t.bn, t.r);
    sb.push_back(t);
    tick();
    e = sb.pop_front();
    chk($sformatf("row%0d_credit", idx), int'(credit), int'(e.credit));
    chk($sformatf("row%0d_money",  idx), int'(money),  int'(therm(e.credit)));
    chk($sformatf("row%0d_vend",   idx), int'(vend),   int'(e.vend));
    chk($sformatf("row%0d_change", idx), int'(change), int'(e.change));
    chk($sformatf("row%0d_reject", idx), int'(reject), int'(e.reject));
    chk($sformatf("row%0d_busy",   idx), int'(busy),   int'(e.busy));
    chk($sformatf("row%0d_enough", idx), int'(enough), int'(e.enough));
  endtask

  initial begin
    int pulses;
    // a  b  bn r   cr v  ch rj bz en
    add(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);  // refund with no credit ignored
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) add(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);  // held coin_a
    add(0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 3, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 3, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0, 0, 1, 0);  // exact-price vend
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 2, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 2, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 4, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 4, 0, 0, 0, 0, 1);
    add(0, 1, 1, 0, 4, 0, 0, 1, 0, 1);  // overflow reject at 4
    add(0, 0, 1, 0, 4, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 1, 0, 0, 1, 0);  // vend with remainder 1
    add(0, 0, 1, 0, 1, 0, 1, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 2, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 2, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 2, 0, 0, 1, 0, 0);  // 2 + 3 rejected as a whole
    add(0, 0, 1, 0, 2, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 2, 0, 1, 0, 1, 0);  // refund of 2
    add(0, 0, 1, 0, 1, 0, 0, 0, 1, 0);
    add(0, 0, 1, 0, 1, 0, 0, 0, 1, 0);
    add(0, 0, 1, 0, 1, 0, 1, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 4, 0, 0, 0, 0, 1);  // 1 + 3 accepted
    add(0, 0, 1, 0, 4, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    add(0, 0, 1, 0, 1, 0, 1, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 3, 0, 0, 0, 0, 1);
    add(1, 1, 1, 1, 3, 0, 1, 0, 1, 0);  // refund of 3, gap 2
    add(0, 0, 1, 0, 2, 0, 0, 0, 1, 0);
    add(1, 0, 1, 0, 2, 0, 0, 1, 1, 0);  // coin during payout
    add(0, 0, 0, 0, 2, 0, 1, 0, 1, 0);  // buy during payout ignored
    add(0, 0, 1, 1, 1, 0, 0, 0, 1, 0);  // refund during payout ignored
    add(0, 0, 1, 0, 1, 0, 0, 0, 1, 0);
    add(0, 0, 1, 0, 1, 0, 1, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);  // buy below price ignored
    add(1, 1, 1, 0, 3, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 3, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 4, 0, 0, 0, 0, 1);  // coin wins, buy dropped
    add(0, 0, 0, 0, 4, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 4, 0, 0, 0, 0, 1);

    drive(0, 0, 1, 0);
    Reset = 1'b0;
    repeat (3) tick();
    chk("rst_credit", int'(credit), 0);
    chk("rst_money",  int'(money),  0);
    chk("rst_vend",   int'(vend),   0);
    chk("rst_change", int'(change), 0);
    chk("rst_reject", int'(reject), 0);
    chk("rst_busy",   int'(busy),   0);
    chk("rst_enough", int'(enough), 0);
    chk("rst_keep_credit", int'(k_credit), 0);
    Reset = 1'b1;

    foreach (tbl[i]) step(i, tbl[i]);

    // Keep-remainder mode on the second instance.
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    drive(0, 1, 1, 0); tick();
    chk("keep_credit_2", int'(k_credit), 2);
    drive(0, 0, 1, 0); tick();
    drive(0, 1, 1, 0); tick();
    drive(0, 0, 1, 0); tick();
    chk("keep_credit_4", int'(k_credit), 4);
    chk("keep_enough_4", int'(k_enough), 1);
    drive(0, 0, 0, 0); tick();
    chk("keep_vend",      int'(k_vend),   1);
    chk("keep_credit_v",  int'(k_credit), 1);
    drive(0, 0, 1, 0); tick();
    chk("keep_vend_off",  int'(k_vend),   0);
    chk("keep_change",    int'(k_change), 0);
    chk("keep_busy",      int'(k_busy),   0);
    chk("keep_credit_1",  int'(k_credit), 1);
    chk("keep_enough",    int'(k_enough), 0);
    tick();
    chk("keep_change_2",  int'(k_change), 0);
    chk("keep_credit_end", int'(k_credit), 1);

    // Reset asserted after the first change pulse of a 3-unit refund.
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    drive(1, 1, 1, 0); tick();
    chk("mid_credit_3", int'(credit), 3);
    drive(0, 0, 1, 1); tick();
    chk("mid_first_pulse", int'(change), 1);
    drive(0, 0, 1, 0); tick();
    chk("mid_credit_2", int'(credit), 2);
    #2 Reset = 1'b0;
    #1;
    chk("mid_rst_credit", int'(credit), 0);
    chk("mid_rst_change", int'(change), 0);
    chk("mid_rst_busy",   int'(busy),   0);
    chk("mid_rst_money",  int'(money),  0);
    @(negedge Hz);
    Reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (change) pulses++;
      chk($sformatf("mid_post_credit%0d", i), int'(credit), 0);
    end
    chk("mid_post_pulses", pulses, 0);
    chk("mid_post_enough", int'(enough), 0);
    chk("mid_post_busy",   int'(busy),   0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
